// File: rtl/phrase_addsat_seq_pkg.sv
// phrase_addsat_seq_pkg: shared lane geometry and sequencer state encoding
package phrase_addsat_seq_pkg;
  localparam int LANES = 4;
  localparam int LANEW = 16;
  localparam int PW = LANES * LANEW;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;
endpackage

// File: rtl/phrase_addsat_seq_if.sv
// phrase_addsat_seq_if: request/result bundle for the phrase adder
//   start/ready/done handshake, a/b phrases, add controls, r/co_vec results
interface phrase_addsat_seq_if;
  import phrase_addsat_seq_pkg::*;
  logic start;
  logic [PW-1:0] a;
  logic [PW-1:0] b;
  logic cin;
  logic sat;
  logic eightbit;
  logic hicinh;
  logic chain;
  logic [LANES-1:0] lane_en;
  logic ready;
  logic done;
  logic [PW-1:0] r;
  logic [LANES-1:0] co_vec;
  modport master (
    output start, a, b, cin, sat, eightbit, hicinh, chain, lane_en,
    input ready, done, r, co_vec
  );
  modport slave (
    input start, a, b, cin, sat, eightbit, hicinh, chain, lane_en,
    output ready, done, r, co_vec
  );
endinterface

// File: rtl/phrase_addsat_seq_add16sat.sv
// add16sat: 16-bit unsigned-plus-signed-delta adder with optional clamp
//   a, b, cin      operands (b MSB is the delta sign)
//   sat            clamp when carry out differs from the delta sign
//   eightbit       low byte clamps on its own carry; high byte adds without it
//   hicinh         blocks the carry into bits 12..15
//   r, co          sum and carry out (bit-7 carry in byte mode)
module add16sat (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  input  logic        sat,
  input  logic        eightbit,
  input  logic        hicinh,
  output logic [15:0] r,
  output logic        co
);
  logic [8:0] lo;
  logic [4:0] mid;
  logic [4:0] hi;
  logic clamp;
  assign lo = {1'b0, a[7:0]} + {1'b0, b[7:0]} + {8'd0, cin};
  assign mid = {1'b0, a[11:8]} + {1'b0, b[11:8]} + {4'd0, ~eightbit & lo[8]};
  assign hi = {1'b0, a[15:12]} + {1'b0, b[15:12]} + {4'd0, ~hicinh & mid[4]};
  assign co = eightbit ? lo[8] : hi[4];
  assign clamp = sat & (co ^ (eightbit ? b[7] : b[15]));
  assign r = !clamp ? {hi[3:0], mid[3:0], lo[7:0]} :
             eightbit ? {hi[3:0], mid[3:0], {8{co}}} : {16{co}};
endmodule

// File: rtl/phrase_addsat_seq.sv
// phrase_addsat_seq: runs one add16sat over the four lanes of a 64-bit phrase
//   clk, resetl    clock and async active-low reset
//   bus            slave side of phrase_addsat_seq_if (start/ready/done, a/b, controls, r/co_vec)
module phrase_addsat_seq
  import phrase_addsat_seq_pkg::*;
(
  input logic clk,
  input logic resetl,
  phrase_addsat_seq_if.slave bus
);
  state_t state, state_nx;
  logic [1:0] lane;
  logic [PW-1:0] a_q, b_q, r_q;
  logic [LANES-1:0] en_q, co_q;
  logic cin_q, sat_q, eb_q, hc_q, ch_q;
  logic [LANEW-1:0] a_l, b_l, s_l;
  logic ci_l, co_l, accept;
  assign accept = (state == IDLE) && bus.start;
  assign a_l = a_q[lane*LANEW +: LANEW];
  assign b_l = b_q[lane*LANEW +: LANEW];
  // chained mode ripples the previous lane's registered carry; a masked lane left 0 there
  assign ci_l = (ch_q && lane != 2'd0) ? co_q[lane-2'd1] : cin_q;
  add16sat u_add (
    .a(a_l), .b(b_l), .cin(ci_l), .sat(sat_q), .eightbit(eb_q), .hicinh(hc_q),
    .r(s_l), .co(co_l)
  );
  always_comb begin
    state_nx = state;
    state_nx = state == IDLE ? (bus.start ? RUN : IDLE) :
               state == RUN ? (lane == 2'd3 ? DONE : RUN) : IDLE;
  end
  always_ff @(posedge clk or negedge resetl) begin
    if (!resetl) begin
      state <= IDLE;
      lane <= 2'd0;
      a_q <= '0;
      b_q <= '0;
      r_q <= '0;
      en_q <= '0;
      co_q <= '0;
      cin_q <= 1'b0;
      sat_q <= 1'b0;
      eb_q <= 1'b0;
      hc_q <= 1'b0;
      ch_q <= 1'b0;
    end else begin
      state <= state_nx;
      if (accept) begin
        a_q <= bus.a;
        b_q <= bus.b;
        cin_q <= bus.cin;
        sat_q <= bus.sat & ~bus.chain;
        eb_q <= bus.eightbit;
        hc_q <= bus.hicinh;
        ch_q <= bus.chain;
        en_q <= bus.lane_en;
        lane <= 2'd0;
      end
      if (state == RUN) begin
        r_q[lane*LANEW +: LANEW] <= en_q[lane] ? s_l : a_l;
        co_q[lane] <= en_q[lane] & co_l;
        lane <= lane + 2'd1;
      end
    end
  end
  assign bus.ready = state == IDLE;
  assign bus.done = state == DONE;
  assign bus.r = r_q;
  assign bus.co_vec = co_q;
endmodule
